// File: rtl/cuckoo_lookup.sv
// Read side of the two-table cuckoo key/value store: looks a key up in both
// tables in parallel, reports hit/miss and optionally clears the matching slots.
module cuckoo_lookup #(
    parameter int KEY_W = 32,
    parameter int VAL_W = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and the payload is held stable while valid
    // is high and ready is low.
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [KEY_W-1:0] req_key,
    input  logic             req_del,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic             rsp_tbl,
    output logic [IDX_W-1:0] rsp_idx,
    output logic [VAL_W-1:0] rsp_val,
    output logic             rsp_dup,
    input  logic             ins_busy,
    output logic [IDX_W-1:0] t1_raddr,
    input  logic [KEY_W-1:0] t1_rkey,
    input  logic [VAL_W-1:0] t1_rval,
    input  logic             t1_rocc,
    output logic             t1_clr,
    output logic [IDX_W-1:0] t2_raddr,
    input  logic [KEY_W-1:0] t2_rkey,
    input  logic [VAL_W-1:0] t2_rval,
    input  logic             t2_rocc,
    output logic             t2_clr,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CMP  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [KEY_W-1:0] key_q;
    logic             del_q;
    logic             accept;
    logic             m1;
    logic             m2;
    logic [IDX_W-1:0] h1_req;
    logic [IDX_W-1:0] h2_req;

    // Addresses are registered at accept time, so they equal the hashes of the
    // latched key and stay put until the next request is accepted.
    assign h1_req = req_key[IDX_W-1:0];
    assign h2_req = req_key[IDX_W-1:0] ^ req_key[KEY_W-1 -: IDX_W];

    assign m1 = t1_rocc && (t1_rkey == key_q);
    assign m2 = t2_rocc && (t2_rkey == key_q);

    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !ins_busy && !rst;
                accept    = req_valid && !ins_busy;
                if (accept) state_nxt = RD;
            end
            RD:   state_nxt = CMP;
            CMP:  state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            key_q    <= '0;
            del_q    <= 1'b0;
            t1_raddr <= '0;
            t2_raddr <= '0;
            t1_clr   <= 1'b0;
            t2_clr   <= 1'b0;
            rsp_hit  <= 1'b0;
            rsp_tbl  <= 1'b0;
            rsp_dup  <= 1'b0;
            rsp_idx  <= '0;
            rsp_val  <= '0;
        end else begin
            state <= state_nxt;
            // Clear pulses fire only on the CMP->RESP edge, i.e. together with
            // the first cycle of rsp_valid, and never repeat while RESP waits.
            t1_clr <= (state == CMP) && del_q && m1;
            t2_clr <= (state == CMP) && del_q && m2;
            if (accept) begin
                key_q    <= req_key;
                del_q    <= req_del;
                t1_raddr <= h1_req;
                t2_raddr <= h2_req;
            end
            if (state == CMP) begin
                rsp_hit <= m1 || m2;
                rsp_dup <= m1 && m2;
                rsp_tbl <= !m1 && m2;
                rsp_idx <= m1 ? t1_raddr : t2_raddr;
                rsp_val <= m1 ? t1_rval : (m2 ? t2_rval : '0);
            end
        end
    end

endmodule

// File: tb/tb_cuckoo_lookup.sv
// Bench for cuckoo_lookup: behavioural table RAMs, randomized requests and a
// queue-based scoreboard fed by the driver and drained by a response monitor.
module tb_cuckoo_lookup;

    localparam int KW = 32;
    localparam int VW = 32;
    localparam int IW = 5;
    localparam int DEPTH = 1 << IW;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [KW-1:0] req_key = '0;
    logic          req_del = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_hit;
    logic          rsp_tbl;
    logic [IW-1:0] rsp_idx;
    logic [VW-1:0] rsp_val;
    logic          rsp_dup;
    logic          ins_busy = 1'b0;
    logic [IW-1:0] t1_raddr;
    logic [KW-1:0] t1_rkey;
    logic [VW-1:0] t1_rval;
    logic          t1_rocc;
    logic          t1_clr;
    logic [IW-1:0] t2_raddr;
    logic [KW-1:0] t2_rkey;
    logic [VW-1:0] t2_rval;
    logic          t2_rocc;
    logic          t2_clr;
    logic [1:0]    dbg_state;

    cuckoo_lookup #(.KEY_W(KW), .VAL_W(VW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_del(req_del),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_tbl(rsp_tbl),
        .rsp_idx(rsp_idx), .rsp_val(rsp_val), .rsp_dup(rsp_dup), .ins_busy(ins_busy),
        .t1_raddr(t1_raddr), .t1_rkey(t1_rkey), .t1_rval(t1_rval), .t1_rocc(t1_rocc), .t1_clr(t1_clr),
        .t2_raddr(t2_raddr), .t2_rkey(t2_rkey), .t2_rval(t2_rval), .t2_rocc(t2_rocc), .t2_clr(t2_clr),
        .dbg_state(dbg_state)
    );

    // table RAMs: one-cycle read latency, clear port, and a bench write port
    logic [KW-1:0] t1k [DEPTH];
    logic [VW-1:0] t1v [DEPTH];
    logic          t1o [DEPTH];
    logic [KW-1:0] t2k [DEPTH];
    logic [VW-1:0] t2v [DEPTH];
    logic          t2o [DEPTH];
    logic          wr_en = 1'b0;
    logic          wr_tbl = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [KW-1:0] wr_key = '0;
    logic [VW-1:0] wr_val = '0;
    logic          wr_occ = 1'b0;
    logic          wipe = 1'b0;

    always @(posedge clk) begin
        t1_rkey <= t1k[t1_raddr];
        t1_rval <= t1v[t1_raddr];
        t1_rocc <= t1o[t1_raddr];
        t2_rkey <= t2k[t2_raddr];
        t2_rval <= t2v[t2_raddr];
        t2_rocc <= t2o[t2_raddr];
        if (t1_clr) t1o[t1_raddr] <= 1'b0;
        if (t2_clr) t2o[t2_raddr] <= 1'b0;
        if (wipe) begin
            for (int i = 0; i < DEPTH; i++) begin
                t1o[i] <= 1'b0;
                t2o[i] <= 1'b0;
                t1k[i] <= '0;
                t2k[i] <= '0;
                t1v[i] <= '0;
                t2v[i] <= '0;
            end
        end
        if (wr_en) begin
            if (!wr_tbl) begin
                t1k[wr_idx] <= wr_key;
                t1v[wr_idx] <= wr_val;
                t1o[wr_idx] <= wr_occ;
            end else begin
                t2k[wr_idx] <= wr_key;
                t2v[wr_idx] <= wr_val;
                t2o[wr_idx] <= wr_occ;
            end
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    typedef struct packed {
        logic          hit;
        logic          tbl;
        logic          dup;
        logic          c1;
        logic          c2;
        logic [IW-1:0] idx;
        logic [IW-1:0] h1;
        logic [IW-1:0] h2;
        logic [VW-1:0] val;
        logic [31:0]   acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   in_flight = 1'b0;
    bit   prev_v = 1'b0;
    bit   hold_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Reference lookup straight from the table contents.
    function automatic exp_t model(input logic [KW-1:0] k, input logic d);
        exp_t        e;
        int unsigned a;
        int unsigned b;
        bit          m1;
        bit          m2;
        a  = k % DEPTH;
        b  = (k % DEPTH) ^ (k >> (KW - IW));
        m1 = t1o[a] && (t1k[a] == k);
        m2 = t2o[b] && (t2k[b] == k);
        e.hit = m1 || m2;
        e.dup = m1 && m2;
        e.tbl = !m1 && m2;
        e.idx = m1 ? IW'(a) : IW'(b);
        e.h1  = IW'(a);
        e.h2  = IW'(b);
        e.val = m1 ? t1v[a] : (m2 ? t2v[b] : '0);
        e.c1  = d && m1;
        e.c2  = d && m2;
        e.acc = '0;
        return e;
    endfunction

    // response rsp_ready driver
    initial begin
        forever begin
            @(negedge clk);
            rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: samples 2 time units after the falling edge
    always @(negedge clk) begin
        exp_t e;
        bit   first;
        #2;
        if (rst) begin
            in_flight = 1'b0;
            prev_v    = 1'b0;
        end else begin
            first = rsp_valid && !prev_v;
            if (in_flight) chk("ready_in_flight", {31'd0, req_ready}, 32'd0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("rsp_hit", {31'd0, rsp_hit}, {31'd0, e.hit});
                    chk("rsp_tbl", {31'd0, rsp_tbl}, {31'd0, e.tbl});
                    chk("rsp_dup", {31'd0, rsp_dup}, {31'd0, e.dup});
                    chk("rsp_idx", 32'(rsp_idx), 32'(e.idx));
                    chk("rsp_val", rsp_val, e.val);
                    if (first) begin
                        chk("latency", cyc - e.acc, 32'd2);
                        chk("t1_clr", {31'd0, t1_clr}, {31'd0, e.c1});
                        chk("t2_clr", {31'd0, t2_clr}, {31'd0, e.c2});
                        if (e.c1) chk("t1_clr_addr", 32'(t1_raddr), 32'(e.h1));
                        if (e.c2) chk("t2_clr_addr", 32'(t2_raddr), 32'(e.h2));
                    end
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        in_flight = 1'b0;
                    end
                end
            end
            if (!first && (t1_clr || t2_clr)) chk("stray_clr", {30'd0, t1_clr, t2_clr}, 32'd0);
            if (req_valid && req_ready) in_flight = 1'b1;
            prev_v = rsp_valid && !rsp_ready;
        end
    end

    // driver tasks
    task automatic wr(input bit tbl, input int idx, input logic [KW-1:0] k,
                      input logic [VW-1:0] v, input bit o);
        @(negedge clk);
        wr_en  = 1'b1;
        wr_tbl = tbl;
        wr_idx = IW'(idx);
        wr_key = k;
        wr_val = v;
        wr_occ = o;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_req(input logic [KW-1:0] k, input bit d, input bit push, input int bc);
        exp_t e;
        bit   ok;
        int   busy_left;
        ok = 1'b0;
        busy_left = bc;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ins_busy  = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            req_valid = 1'b1;
            req_key   = k;
            req_del   = d;
            #1;
            if (ins_busy) begin
                chk("ready_while_busy", {31'd0, req_ready}, 32'd0);
            end else if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else if (push) begin
            e = model(k, d);
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        ins_busy  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !in_flight) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            chk("rsp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [KW-1:0] k;
        logic [KW-1:0] k1;
        logic [KW-1:0] k2;
        int            a;
        int            b;
        int            mode;
        bit            d;

        // reset behaviour, including a pending request during rst
        req_valid = 1'b1;
        req_key   = 32'h0000_0023;
        wipe      = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_rsp_fields", {rsp_hit, rsp_tbl, rsp_dup, 29'd0}, 32'd0);
        chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
        chk("rst_rsp_val", rsp_val, 32'd0);
        chk("rst_raddr", {22'd0, t1_raddr, t2_raddr}, 32'd0);
        chk("rst_clr", {30'd0, t1_clr, t2_clr}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        wipe      = 1'b0;

        // table 1 hit
        wr(0, 5'h03, 32'h0000_0023, 32'hAAAA_0001, 1);
        do_req(32'h0000_0023, 0, 1, 0);
        wait_done();

        // table 2 only hit, then the same slot unoccupied
        wr(1, 5'h1E, 32'hF800_0001, 32'hBBBB_0002, 1);
        do_req(32'hF800_0001, 0, 1, 2);
        wait_done();
        wr(1, 5'h1E, 32'hF800_0001, 32'hBBBB_0002, 0);
        do_req(32'hF800_0001, 0, 1, 0);
        wait_done();

        // delete from table 1, then re-lookup
        wr(0, 5'h05, 32'h0000_0045, 32'hCCCC_0003, 1);
        do_req(32'h0000_0045, 1, 1, 0);
        wait_done();
        do_req(32'h0000_0045, 0, 1, 0);
        wait_done();

        // key in both tables, delete clears both
        wr(1, 5'h03, 32'h0000_0023, 32'hDDDD_0004, 1);
        do_req(32'h0000_0023, 1, 1, 0);
        wait_done();
        do_req(32'h0000_0023, 0, 1, 0);
        wait_done();

        // long rsp_ready stall
        wr(0, 5'h07, 32'h1234_5667, 32'hEEEE_0005, 1);
        hold_low = 1'b1;
        do_req(32'h1234_5667, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) break;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        hold_low = 1'b0;
        wait_done();

        // insert engine busy in IDLE blocks acceptance
        do_req(32'h1234_5667, 0, 1, 6);
        wait_done();

        // reset while the request is in CMP with a delete that would hit
        wr(0, 5'h03, 32'h0000_0023, 32'hABCD_0006, 1);
        @(negedge clk);
        ins_busy  = 1'b0;
        req_valid = 1'b1;
        req_key   = 32'h0000_0023;
        req_del   = 1'b1;
        #1;
        chk("t6_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_rst_clr", {30'd0, t1_clr, t2_clr}, 32'd0);
        chk("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        do_req(32'h0000_0023, 0, 1, 0);
        wait_done();

        // randomized phase
        for (int it = 0; it < 60; it++) begin
            k = $urandom;
            if ($urandom_range(0, 3) == 0) k[KW-1 -: IW] = '0;
            a    = int'(k % DEPTH);
            b    = int'((k % DEPTH) ^ (k >> (KW - IW)));
            mode = $urandom_range(0, 3);
            k1   = mode[0] ? k : (k ^ (32'h1 << $urandom_range(0, 31)));
            k2   = mode[1] ? k : (k ^ (32'h1 << $urandom_range(0, 31)));
            wr(0, a, k1, $urandom, ($urandom_range(0, 4) != 0));
            wr(1, b, k2, $urandom, ($urandom_range(0, 4) != 0));
            d = 1'($urandom_range(0, 1));
            do_req(k, d, 1, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) do_req(k, 0, 1, $urandom_range(0, 2));
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
